// File: rtl/ifu.sv
// Instruction fetch unit: issues in-order word reads to instruction SRAM,
// buffers returned words with their PCs and hands them to decode through a
// valid/ready handshake. A redirect from execute flushes buffered words and
// arranges for every still-outstanding response to be dropped on return.
module ifu #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        instr_ready_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] fifo_count;

   logic [31:0]   pend_pc [FIFO_DEPTH];
   logic [PW-1:0] pend_wr;
   logic [PW-1:0] pend_rd;

   logic [31:0]   fifo_pc    [FIFO_DEPTH];
   logic [31:0]   fifo_instr [FIFO_DEPTH];
   logic [PW-1:0] fifo_wr;
   logic [PW-1:0] fifo_rd;

   logic [CW:0]   in_use;
   logic          grant;
   logic          fifo_push;
   logic          fifo_pop;

   // Request credit, handshake events and the decode-facing view of the FIFO head
   always_comb begin
      in_use        = {1'b0, outstanding} + {1'b0, fifo_count};
      mem_req_o     = rst_n && !jump_en_i && (in_use < DEPTH_C);
      mem_addr_o    = fetch_pc;
      grant         = mem_req_o && mem_gnt_i;
      fifo_push     = mem_rvalid_i && (drop_cnt == '0);
      instr_valid_o = (fifo_count != '0);
      fifo_pop      = instr_valid_o && instr_ready_i;
      instr_o       = NOP_INSTR;
      pc_o          = 32'h0;
      if (instr_valid_o) begin
         instr_o = fifo_instr[fifo_rd];
         pc_o    = fifo_pc[fifo_rd];
      end
   end

   // Fetch PC: redirect wins, otherwise advance by one word per grant
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
      end else if (jump_en_i) begin
         fetch_pc <= jump_addr_i & 32'hFFFF_FFFC;
      end else if (grant) begin
         fetch_pc <= fetch_pc + 32'd4;
      end
   end

   // Outstanding-read tracking and count of responses that belong to flushed fetches
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + CW'(grant) - CW'(mem_rvalid_i);
         if (jump_en_i) begin
            drop_cnt <= outstanding - CW'(mem_rvalid_i);
         end else if (mem_rvalid_i && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
         end
      end
   end

   // Pending-PC queue: remembers each granted address until its response returns
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_wr <= '0;
         pend_rd <= '0;
      end else begin
         if (grant) begin
            pend_pc[pend_wr] <= fetch_pc;
            pend_wr          <= pend_wr + 1'b1;
         end
         if (mem_rvalid_i) begin
            pend_rd <= pend_rd + 1'b1;
         end
      end
   end

   // Instruction FIFO pointers and occupancy; a redirect empties it outright
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fifo_wr    <= '0;
         fifo_rd    <= '0;
         fifo_count <= '0;
      end else if (jump_en_i) begin
         fifo_wr    <= '0;
         fifo_rd    <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_push) begin
            fifo_wr <= fifo_wr + 1'b1;
         end
         if (fifo_pop) begin
            fifo_rd <= fifo_rd + 1'b1;
         end
         fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
      end
   end

   // Instruction FIFO storage: the word is tagged with the PC it was fetched from
   always_ff @(posedge clk) begin
      if (fifo_push && !jump_en_i) begin
         fifo_pc[fifo_wr]    <= pend_pc[pend_rd];
         fifo_instr[fifo_wr] <= mem_rdata_i;
      end
   end

endmodule

// File: tb/tb_ifu.sv
// Randomized testbench for ifu: an in-order SRAM responder with random grant
// and latency drives the DUT, and a queue-based reference model predicts every
// output each cycle.
module tb_ifu;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam int          DEPTH    = 2;

   logic        clk;
   logic        rst_n;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        instr_ready_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;

   ifu #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (DEPTH),
      .NOP_INSTR  (NOP)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i),
      .jump_en_i     (jump_en_i),
      .jump_addr_i   (jump_addr_i),
      .instr_ready_i (instr_ready_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .pc_o          (pc_o)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: each issued fetch is a queue entry marked stale when a
   // redirect overtakes it; delivered words live in a second queue.
   typedef struct {
      logic [31:0] pc;
      bit          stale;
      int          due;
   } pend_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   pend_t       m_pend[$];
   ent_t        m_fifo[$];
   logic [31:0] m_pc;

   bit          exp_req;
   bit          exp_valid;
   logic [31:0] exp_instr;
   logic [31:0] exp_pc;

   int checks;
   int failures;
   int cyc;
   int cur_max_lat;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int gnt_pct, input int ready_pct, input int rvalid_pct,
                                input int jump_pct, input int rst_pct);
      rst_n         = !($urandom_range(99, 0) < rst_pct);
      mem_gnt_i     = ($urandom_range(99, 0) < gnt_pct);
      instr_ready_i = ($urandom_range(99, 0) < ready_pct);
      jump_en_i     = rst_n && ($urandom_range(99, 0) < jump_pct);
      if ($urandom_range(3, 0) == 0) begin
         jump_addr_i = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      end else begin
         jump_addr_i = $urandom();
      end
      mem_rvalid_i = rst_n && (m_pend.size() > 0) && ($urandom_range(99, 0) < rvalid_pct);
      if (mem_rvalid_i && (m_pend[0].due > cyc)) begin
         mem_rvalid_i = 1'b0;
      end
      mem_rdata_i = mem_rvalid_i ? memWord(m_pend[0].pc) : $urandom();
   endtask

   task automatic computeExpected();
      exp_req   = !jump_en_i && ((m_pend.size() + m_fifo.size()) < DEPTH);
      exp_valid = (m_fifo.size() > 0);
      exp_instr = exp_valid ? m_fifo[0].instr : NOP;
      exp_pc    = exp_valid ? m_fifo[0].pc : 32'h0;
   endtask

   task automatic stepModel();
      pend_t p;
      ent_t  e;
      bit    grant;
      bit    pop;
      bit    push;
      push = 1'b0;
      if (!rst_n) begin
         m_pend.delete();
         m_fifo.delete();
         m_pc = RESET_PC;
      end else begin
         grant = exp_req && mem_gnt_i;
         pop   = exp_valid && instr_ready_i;
         if (mem_rvalid_i) begin
            p = m_pend.pop_front();
            if (!p.stale) begin
               push    = 1'b1;
               e.pc    = p.pc;
               e.instr = mem_rdata_i;
            end
         end
         if (jump_en_i) begin
            m_fifo.delete();
            for (int i = 0; i < m_pend.size(); i++) begin
               m_pend[i].stale = 1'b1;
            end
            m_pc = jump_addr_i & 32'hFFFF_FFFC;
         end else begin
            if (pop) void'(m_fifo.pop_front());
            if (push) m_fifo.push_back(e);
            if (grant) begin
               m_pend.push_back('{pc: m_pc, stale: 1'b0, due: cyc + $urandom_range(cur_max_lat, 1)});
               m_pc = m_pc + 32'd4;
            end
         end
      end
      cyc++;
   endtask

   task automatic runPhase(input int n, input int gnt_pct, input int ready_pct, input int rvalid_pct,
                           input int jump_pct, input int rst_pct, input int max_lat);
      cur_max_lat = max_lat;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         applyStimulus(gnt_pct, ready_pct, rvalid_pct, jump_pct, rst_pct);
         #1;
         computeExpected();
         if (rst_n) begin
            checkOutput("mem_req",     {31'b0, mem_req_o},     {31'b0, exp_req});
            checkOutput("mem_addr",    mem_addr_o,             m_pc);
            checkOutput("instr_valid", {31'b0, instr_valid_o}, {31'b0, exp_valid});
            checkOutput("instr",       instr_o,                exp_instr);
            checkOutput("pc",          pc_o,                   exp_pc);
         end
         @(posedge clk);
         stepModel();
      end
   endtask

   // Main sequence: reset with directed checks of the reset state, then
   // randomized phases of increasing irregularity
   initial begin
      checks        = 0;
      failures      = 0;
      cyc           = 0;
      cur_max_lat   = 1;
      rst_n         = 1'b0;
      mem_gnt_i     = 1'b0;
      mem_rvalid_i  = 1'b0;
      mem_rdata_i   = 32'h0;
      jump_en_i     = 1'b0;
      jump_addr_i   = 32'h0;
      instr_ready_i = 1'b0;
      m_pc          = RESET_PC;

      repeat (2) begin
         @(posedge clk);
         stepModel();
      end
      @(negedge clk);
      #1;
      checkOutput("rst_req",   {31'b0, mem_req_o},     32'h0);
      checkOutput("rst_addr",  mem_addr_o,             RESET_PC);
      checkOutput("rst_valid", {31'b0, instr_valid_o}, 32'h0);
      checkOutput("rst_instr", instr_o,                NOP);
      checkOutput("rst_pc",    pc_o,                   32'h0);
      @(posedge clk);
      stepModel();

      runPhase(200,  100, 100, 100,  0, 0, 1);
      runPhase(20,   100,   0, 100,  0, 0, 1);
      runPhase(100,  100, 100, 100,  0, 0, 1);
      runPhase(1500,  40,  80,  70, 10, 0, 3);
      runPhase(1500, 100,  50, 100, 15, 2, 1);
      runPhase(1500,  60,  60,  60, 20, 1, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
